// File: rtl/mult_pipe_hs.sv
// Fully pipelined integer multiplier with valid/ready handshakes, a per-operation signed/unsigned
// mode, product-half select and a sideband tag. All stages advance together under backpressure.
module mult_pipe_hs #(
   parameter int unsigned DATA_LEN       = 32,
   parameter int unsigned PIPELINE_STAGE = 2,
   parameter int unsigned TAG_LEN        = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [DATA_LEN-1:0] a,
   input  logic [DATA_LEN-1:0] b,
   input  logic                in_signed,
   input  logic                in_high,
   input  logic [TAG_LEN-1:0]  in_tag,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [DATA_LEN-1:0] result,
   output logic [TAG_LEN-1:0]  out_tag,
   output logic                busy
);

   localparam int unsigned PW = 2 * DATA_LEN;

   logic                      adv;
   logic                      accept;
   logic [PW-1:0]             ext_a;
   logic [PW-1:0]             ext_b;
   logic [PW-1:0]             prod;
   logic [DATA_LEN-1:0]       sel;

   logic [PIPELINE_STAGE-1:0] valid_q;
   logic [DATA_LEN-1:0]       data_q [PIPELINE_STAGE];
   logic [TAG_LEN-1:0]        tag_q  [PIPELINE_STAGE];

   // A 2N-bit multiply of extended operands is exact modulo 2^(2N) in both modes.
   always_comb begin
      ext_a = in_signed ? {{DATA_LEN{a[DATA_LEN-1]}}, a} : {{DATA_LEN{1'b0}}, a};
      ext_b = in_signed ? {{DATA_LEN{b[DATA_LEN-1]}}, b} : {{DATA_LEN{1'b0}}, b};
      prod  = ext_a * ext_b;
      sel   = in_high ? prod[PW-1:DATA_LEN] : prod[DATA_LEN-1:0];
   end

   assign adv       = !out_valid || out_ready;
   assign in_ready  = adv;
   assign accept    = in_valid && adv;
   assign out_valid = valid_q[PIPELINE_STAGE-1];
   assign result    = data_q[PIPELINE_STAGE-1];
   assign out_tag   = tag_q[PIPELINE_STAGE-1];
   assign busy      = |valid_q;

   // Data only moves with a valid operation, so a bubble leaves the last result in place.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q[0] <= 1'b0;
         data_q[0]  <= '0;
         tag_q[0]   <= '0;
      end else if (adv) begin
         valid_q[0] <= accept;
         if (accept) begin
            data_q[0] <= sel;
            tag_q[0]  <= in_tag;
         end
      end
   end

   for (genvar i = 1; i < PIPELINE_STAGE; i++) begin : g_stage
      always_ff @(posedge clk) begin
         if (reset) begin
            valid_q[i] <= 1'b0;
            data_q[i]  <= '0;
            tag_q[i]   <= '0;
         end else if (adv) begin
            valid_q[i] <= valid_q[i-1];
            if (valid_q[i-1]) begin
               data_q[i] <= data_q[i-1];
               tag_q[i]  <= tag_q[i-1];
            end
         end
      end
   end

endmodule

// File: doc/mult_pipe_hs.md
Name: mult_pipe_hs

Overview:
- Parametrised, fully pipelined integer multiplier with valid/ready handshakes on input and output.
- Successor to the fixed single-register multiplier block.
- Adds selectable pipeline depth, per-operation signed/unsigned mode, low/high product-half selection, a sideband tag, and backpressure.
- Sits between the operand fetch stage and the result writeback FIFO in the arithmetic datapath.

Parameters:
- DATA_LEN, 32, operand and result width in bits (>= 2).
- PIPELINE_STAGE, 2, number of register stages from input acceptance to result (>= 1).
- TAG_LEN, 8, width of the sideband tag carried alongside each operation (>= 1).

Ports:
- clk  input  1  clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  input operation is valid.
- in_ready  output  1  block can accept an operation this cycle.
- a  input  DATA_LEN  operand A.
- b  input  DATA_LEN  operand B.
- in_signed  input  1  1 = treat a/b as two's complement; 0 = unsigned.
- in_high  input  1  1 = return product bits [2*DATA_LEN-1:DATA_LEN]; 0 = bits [DATA_LEN-1:0].
- in_tag  input  TAG_LEN  opaque tag travelling with the operation.
- out_valid  output  1  result is valid.
- out_ready  input  1  downstream accepts the result this cycle.
- result  output  DATA_LEN  selected product half.
- out_tag  output  TAG_LEN  tag of the operation currently on result.
- busy  output  1  at least one pipeline stage holds a valid operation.

Behaviour:
- Reset: all stage valid bits 0. out_valid=0, result=0, out_tag=0, busy=0. in_ready=1 in the first cycle after reset deasserts.
- Reset asserted mid-operation discards every in-flight operation; no result is ever presented for them.
- Global advance: adv = !out_valid || out_ready. in_ready = adv, combinational from out_valid and out_ready only, never from in_valid.
- Acceptance:
  - An operation is accepted when in_valid && in_ready.
  - When adv=1, every stage shifts one position. Stage 1 loads the accepted operation, or a bubble (valid=0) if none is accepted.
  - When adv=0, all stage registers (data, valid, mode, tag) hold.
- Bubbles are not compressed; occupancy is at most PIPELINE_STAGE operations.
- Latency: exactly PIPELINE_STAGE cycles from acceptance to out_valid when no stall occurs. Throughput is 1 operation per cycle when out_ready stays high.
- Arithmetic:
  - The full 2*DATA_LEN product is formed in stage 1.
  - Signed mode: both operands sign-extended to 2*DATA_LEN before multiplying. Unsigned mode: zero-extended.
  - The low half is identical in both modes; the high half differs.
  - Half selection uses in_high captured at acceptance. Mode and tag travel through the pipe with their operation.
- No overflow flag, no saturation: results wrap modulo 2^(2*DATA_LEN) before half selection.
- Output hold:
  - While out_valid=1 and out_ready=0, result and out_tag stay stable.
  - When out_valid=0, result and out_tag hold their last values; contents are not significant.
- busy = OR of all stage valid bits, registered state only.
- Simultaneous output handshake and new input in the same cycle: both occur; the pipe stays full with no bubble.
- PIPELINE_STAGE=1: the product and half selection are registered directly into the output stage. Behaviour is otherwise identical.

Test Plan:
- Signed low: DATA_LEN=32, a=0xFFFFFFFD, b=5, in_signed=1, in_high=0, tag=0x11 -> after 2 cycles out_valid=1, result=0xFFFFFFF1, out_tag=0x11.
- Signed vs unsigned high: a=0xFFFFFFFD, b=5, in_high=1; signed -> 0xFFFFFFFF; unsigned -> 0x00000004.
- Corners:
  - unsigned 0xFFFFFFFF*0xFFFFFFFF -> high 0xFFFFFFFE, low 0x00000001.
  - signed 0x80000000*0x80000000 -> high 0x40000000, low 0x00000000.
- Backpressure: stream tags 1..6 back-to-back with out_ready held low for cycles 3-5 -> in_ready=0 exactly while out_valid&&!out_ready. result is stable during the stall. All 6 results are delivered in order with correct tags; none is lost or duplicated.
- Full throughput: 16 random ops, in_valid and out_ready held at 1 -> one result per cycle starting at cycle 2. Each result matches a 64-bit reference model.
- Reset mid-flight: accept 2 ops, then assert reset for 1 cycle -> out_valid=0, busy=0, result=0, out_tag=0 after the reset edge, and neither op ever appears at the output.
